// File: rtl/sbox.sv
// AES forward S-box: multiplicative inverse in GF(2^8) mod 0x11B followed by the
// affine transform. Purely combinational, one byte in, one byte out.
module sbox (
    input  logic [7:0] a,
    output logic [7:0] c
);

    function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] p;
        logic [7:0] s;
        p = 8'h00;
        s = x;
        for (int k = 0; k < 8; k++) begin
            if (y[k]) p = p ^ s;
            s = {s[6:0], 1'b0} ^ (s[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    logic [7:0] inv;

    // Inverse as a^254 by square-and-multiply; 0 maps to 0 naturally.
    always_comb begin
        logic [7:0] sq;
        sq  = a;
        inv = 8'h01;
        for (int k = 1; k < 8; k++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        c = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^
            {inv[3:0], inv[7:4]} ^ 8'h63;
    end

endmodule

// File: rtl/key_expand_seq.sv
// Iterative AES key-schedule engine: loads a 128/192/256-bit key, produces one
// schedule word per clock into an internal register file, and serves 128-bit
// round keys through a registered read port.
// Optional build macro KEY_EXP_REVERSE_EN: read port indexes round keys in
// decrypt order (rk_sel=k returns round key NR-k).
module key_expand_seq #(
    parameter int unsigned KEY_BITS = 192
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [KEY_BITS-1:0] key_in,
    output logic                busy,
    output logic                done,
    output logic                keys_valid,
    input  logic [3:0]          rk_sel,
    output logic [127:0]        rk_out
);

    localparam int unsigned NK = KEY_BITS / 32;
    localparam int unsigned NR = NK + 6;
    localparam int unsigned NW = 4 * (NR + 1);

    localparam logic [5:0] NkIdx   = 6'(NK);
    localparam logic [5:0] LastIdx = 6'(NW - 1);
    localparam logic [3:0] NrSel   = 4'(NR);
    localparam logic [2:0] ModLast = 3'(NK - 1);

    if (!(KEY_BITS == 128 || KEY_BITS == 192 || KEY_BITS == 256)) begin : g_bad_key_bits
        $error("key_expand_seq: KEY_BITS must be 128, 192 or 256");
    end

    typedef enum logic [0:0] {StIdle, StExpand} state_e;

    state_e      state_q, state_d;
    logic [5:0]  i_q, i_d;        // index of the word being written
    logic [2:0]  mod_q, mod_d;    // i % NK, tracked incrementally
    logic [7:0]  rcon_q, rcon_d;
    logic        done_q, done_d;
    logic        kv_q, kv_d;
    logic        load, wr_en;

    logic [31:0] w_q [NW];
    logic [31:0] prev_word, back_word, sub_in, sub_out, t_word, new_word;
    logic [3:0]  rk_idx;
    logic [127:0] rk_d, rk_q;

    assign prev_word = w_q[i_q - 6'd1];
    assign back_word = w_q[i_q - NkIdx];
    assign sub_in    = (mod_q == 3'd0) ? {prev_word[23:0], prev_word[31:24]} : prev_word;

    for (genvar b = 0; b < 4; b++) begin : g_sbox
        sbox u_sbox (
            .a (sub_in[8*b +: 8]),
            .c (sub_out[8*b +: 8])
        );
    end

    // Select the mixing term for the current word.
    always_comb begin
        t_word = prev_word;
        if (mod_q == 3'd0) begin
            t_word = sub_out ^ {rcon_q, 24'h0};
        end else if (NK == 8 && mod_q == 3'd4) begin
            t_word = sub_out;
        end
        new_word = back_word ^ t_word;
    end

    // Next-state logic for the expansion sequencer.
    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        mod_d   = mod_q;
        rcon_d  = rcon_q;
        done_d  = 1'b0;
        kv_d    = kv_q;
        load    = 1'b0;
        wr_en   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    load    = 1'b1;
                    i_d     = NkIdx;
                    mod_d   = 3'd0;
                    rcon_d  = 8'h01;
                    kv_d    = 1'b0;
                    state_d = StExpand;
                end
            end
            StExpand: begin
                wr_en = 1'b1;
                if (mod_q == 3'd0) begin
                    rcon_d = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
                end
                mod_d = (mod_q == ModLast) ? 3'd0 : mod_q + 3'd1;
                if (i_q == LastIdx) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                    kv_d    = 1'b1;
                end else begin
                    i_d = i_q + 6'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Sequencer and status registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            i_q     <= NkIdx;
            mod_q   <= 3'd0;
            rcon_q  <= 8'h01;
            done_q  <= 1'b0;
            kv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            mod_q   <= mod_d;
            rcon_q  <= rcon_d;
            done_q  <= done_d;
            kv_q    <= kv_d;
        end
    end

    // Schedule storage; deliberately not cleared by reset.
    always_ff @(posedge clk) begin
        if (load) begin
            for (int unsigned j = 0; j < NK; j++) begin
                w_q[j] <= key_in[KEY_BITS-1-32*j -: 32];
            end
        end else if (wr_en) begin
            w_q[i_q] <= new_word;
        end
    end

    // Round-key read mux; out-of-range or invalid schedule reads as zero.
    always_comb begin
        rk_idx = 4'd0;
        if (rk_sel <= NrSel) begin
`ifdef KEY_EXP_REVERSE_EN
            rk_idx = NrSel - rk_sel;
`else
            rk_idx = rk_sel;
`endif
        end
        rk_d = '0;
        if (kv_q && rk_sel <= NrSel) begin
            rk_d = {w_q[{rk_idx, 2'b00}], w_q[{rk_idx, 2'b01}],
                    w_q[{rk_idx, 2'b10}], w_q[{rk_idx, 2'b11}]};
        end
    end

    // Registered read port.
    always_ff @(posedge clk) begin
        if (rst) begin
            rk_q <= '0;
        end else begin
            rk_q <= rk_d;
        end
    end

    assign busy       = (state_q == StExpand);
    assign done       = done_q;
    assign keys_valid = kv_q;
    assign rk_out     = rk_q;

endmodule
